// File: rtl/switch_module.sv
// Shared-buffer crossbar switch with one virtual output queue per
// (destination, source) pair. Ingress words are steered into VOQ[rx][src];
// each egress pops from the source selected by an external scheduler.
// Optional build macro SWITCH_STATUS_EN adds a voq_nempty status output
// (one bit per VOQ) for the scheduler.
module switch_module #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH_SEL  = $clog2(PORT_NUB),
    parameter int WIDTH_PORT = 1 + 2*WIDTH_SEL + DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUB*WIDTH_PORT-1:0] port_in,
    input  logic [PORT_NUB*WIDTH_SEL-1:0]  rd_sel,
    input  logic [PORT_NUB-1:0]            rd_en,
    output logic [PORT_NUB*WIDTH_PORT-1:0] port_out
`ifdef SWITCH_STATUS_EN
    ,
    output logic [PORT_NUB*PORT_NUB-1:0]   voq_nempty
`endif
);

    localparam int NQ = PORT_NUB * PORT_NUB;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = 2*WIDTH_SEL + DATA_WIDTH;

    // Per-VOQ status and head-of-queue word, flattened by index dst*PORT_NUB+src.
    logic [NQ-1:0]    q_empty;
    logic [NQ-1:0]    q_full;
    logic [NQ*WW-1:0] head_flat;

    for (genvar d = 0; d < PORT_NUB; d++) begin : g_dst
        for (genvar s = 0; s < PORT_NUB; s++) begin : g_src
            localparam int Q = d*PORT_NUB + s;

            logic [AW:0]          wr_ptr;
            logic [AW:0]          rd_ptr;
            logic [WW-1:0]        mem [FIFO_DEPTH];
            logic                 in_valid;
            logic [WIDTH_SEL-1:0] in_rx;
            logic                 pop_ok;
            logic                 push_ok;

            assign in_valid = port_in[s*WIDTH_PORT + WIDTH_PORT - 1];
            assign in_rx    = port_in[s*WIDTH_PORT + WW - 1 -: WIDTH_SEL];

            assign q_empty[Q] = (wr_ptr == rd_ptr);
            assign q_full[Q]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

            assign pop_ok  = rd_en[d] &&
                             (rd_sel[d*WIDTH_SEL +: WIDTH_SEL] == WIDTH_SEL'(s)) &&
                             !q_empty[Q];
            // A pop in the same cycle frees the slot, so a full queue still accepts.
            assign push_ok = in_valid && (in_rx == WIDTH_SEL'(d)) &&
                             (!q_full[Q] || pop_ok);

            assign head_flat[Q*WW +: WW] = mem[rd_ptr[AW-1:0]];

            // Advance pointers on accepted push / successful pop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                    if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                end
            end

            // Storage write; contents need no reset since the pointers gate visibility.
            always_ff @(posedge clk) begin
                if (push_ok) mem[wr_ptr[AW-1:0]] <= port_in[s*WIDTH_PORT +: WW];
            end
        end
    end

    for (genvar n = 0; n < PORT_NUB; n++) begin : g_egress
        logic [WIDTH_SEL-1:0]   sel;
        logic [2*WIDTH_SEL-1:0] idx;
        logic                   pop;
        logic [WIDTH_PORT-1:0]  out_q;

        assign sel = rd_sel[n*WIDTH_SEL +: WIDTH_SEL];
        // PORT_NUB is a power of two, so {dst, src} is the flat VOQ index.
        assign idx = {WIDTH_SEL'(n), sel};
        assign pop = rd_en[n] && !q_empty[idx];

        // Register the popped word; idle or empty reads present all zeros.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= '0;
            end else if (pop) begin
                out_q <= {1'b1, head_flat[idx*WW +: WW]};
            end else begin
                out_q <= '0;
            end
        end

        assign port_out[n*WIDTH_PORT +: WIDTH_PORT] = out_q;
    end

`ifdef SWITCH_STATUS_EN
    assign voq_nempty = ~q_empty;
`endif

endmodule

// File: tb/tb_switch_module.sv
// Scoreboard bench for switch_module (4 ports, 8-bit data, depth 4).
module tb_switch_module;

    localparam int N  = 4;
    localparam int WS = 2;
    localparam int WP = 1 + 2*WS + 8;

    logic              clk;
    logic              rst;
    logic [N*WP-1:0]   port_in;
    logic [N*WS-1:0]   rd_sel;
    logic [N-1:0]      rd_en;
    logic [N*WP-1:0]   port_out;
`ifdef SWITCH_STATUS_EN
    logic [N*N-1:0]    voq_nempty;
`endif

    switch_module #(.PORT_NUB(N), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .port_in  (port_in),
        .rd_sel   (rd_sel),
        .rd_en    (rd_en),
        .port_out (port_out)
`ifdef SWITCH_STATUS_EN
        ,
        .voq_nempty (voq_nempty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          in_v  [N];
    logic [1:0]    in_rx [N];
    logic [1:0]    in_tx [N];
    logic [7:0]    in_d  [N];
    logic [1:0]    rs    [N];
    logic          re    [N];

    logic [WP-1:0] exp_q [N][$];
    int            tests;
    int            fails;
    logic          mon_en;

    always_comb begin
        port_in = '0;
        rd_sel  = '0;
        rd_en   = '0;
        for (int i = 0; i < N; i++) begin
            port_in[i*WP +: WP] = {in_v[i], in_rx[i], in_tx[i], in_d[i]};
            rd_sel[i*WS +: WS]  = rs[i];
            rd_en[i]            = re[i];
        end
    end

    // Monitor: every valid egress word must match the oldest expectation for that egress.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int n = 0; n < N; n++) begin
                logic [WP-1:0] w;
                logic [WP-1:0] e;
                w = port_out[n*WP +: WP];
                tests++;
                if (w[WP-1]) begin
                    if (exp_q[n].size() == 0) begin
                        fails++;
                        $display("FAIL egress%0d_unexpected: got %h, required no valid word", n, w);
                    end else begin
                        e = exp_q[n].pop_front();
                        if (w !== e) begin
                            fails++;
                            $display("FAIL egress%0d_word: got %h, required %h", n, w, e);
                        end
                    end
                end else if (w !== '0) begin
                    fails++;
                    $display("FAIL egress%0d_idle_zero: got %h, required 0", n, w);
                end
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            in_v[i] = 1'b0; in_rx[i] = '0; in_tx[i] = '0; in_d[i] = '0;
            rs[i] = '0; re[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic push(input int i, input logic [1:0] rx, input logic [1:0] tx, input logic [7:0] d);
        in_v[i] = 1'b1; in_rx[i] = rx; in_tx[i] = tx; in_d[i] = d;
    endtask

    task automatic rd(input int n, input int m, input bit exp_v, input logic [1:0] tx, input logic [7:0] d);
        rs[n] = 2'(m);
        re[n] = 1'b1;
        if (exp_v) exp_q[n].push_back({1'b1, 2'(n), tx, d});
    endtask

    task automatic check(input string name, input logic [N*WP-1:0] got, input logic [N*WP-1:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        mon_en = 1'b1;
        clr();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", port_out, '0);
        rst = 1'b0;

        // Single word through VOQ[3][0].
        push(0, 2'd3, 2'd0, 8'hA5);
        tick();
        rd(3, 0, 1'b1, 2'd0, 8'hA5);
        tick();
        tick();

        // Full traffic: ingress j to egress 3-j for 20 cycles; only first 4 words kept.
        for (int c = 0; c < 20; c++) begin
            for (int j = 0; j < N; j++) push(j, 2'(3 - j), 2'(j), 8'(16*j + c));
            tick();
        end
        for (int m = 0; m < N; m++) begin
            for (int n = 0; n < N; n++) rd(n, m, (m == 3 - n), 2'(3 - n), 8'(16*(3 - n)));
            tick();
        end
        tick();

        // Async reset mid-cycle with a valid egress word and pending ingress traffic.
        mon_en = 1'b0;
        rd(0, 3, 1'b0, 2'd0, 8'h00);
        push(1, 2'd0, 2'd1, 8'h77);
        tick();
        check("pre_reset_word", port_out, {{(3*WP){1'b0}}, 1'b1, 2'd0, 2'd3, 8'h31});
        #2;
        rst = 1'b1;
        #1;
        check("reset_immediate", port_out, '0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int m = 0; m < N; m++) begin
            for (int n = 0; n < N; n++) rd(n, m, 1'b0, 2'd0, 8'h00);
            tick();
        end
        tick();

        // Overflow of VOQ[1][2]: words 4 and 5 are dropped.
        for (int k = 0; k < 6; k++) begin
            push(2, 2'd1, 2'd2, 8'(k));
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            rd(1, 2, (k < 4), 2'd2, 8'(k));
            tick();
        end
        tick();

        // Simultaneous push and pop on a full VOQ[0][1].
        for (int k = 0; k < 4; k++) begin
            push(1, 2'd0, 2'd1, 8'(k));
            tick();
        end
        push(1, 2'd0, 2'd1, 8'd9);
        rd(0, 1, 1'b1, 2'd1, 8'd0);
        tick();
        rd(0, 1, 1'b1, 2'd1, 8'd1); tick();
        rd(0, 1, 1'b1, 2'd1, 8'd2); tick();
        rd(0, 1, 1'b1, 2'd1, 8'd3); tick();
        rd(0, 1, 1'b1, 2'd1, 8'd9); tick();
        rd(0, 1, 1'b0, 2'd0, 8'd0); tick();
        tick();

        // Empty read leaves pointers alone; minimum-latency push then pop.
        rd(2, 0, 1'b0, 2'd0, 8'h00);
        tick();
        push(0, 2'd2, 2'd1, 8'h5C);
        tick();
        rd(2, 0, 1'b1, 2'd1, 8'h5C);
        tick();
        tick();
        tick();

        for (int n = 0; n < N; n++) begin
            tests++;
            if (exp_q[n].size() != 0) begin
                fails++;
                $display("FAIL egress%0d_missing: got %0d words outstanding, required 0", n, exp_q[n].size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
